// File: rtl/csr_exec_unit.sv
// Zicsr sequencer: one request is turned into an optional read cycle and an
// optional write cycle on the csr block, then answered on a valid/ready response port.
//   state | meaning
//   IDLE  | ready for a request
//   READ  | read strobe to csr, capture old value and illegal flag
//   WRITE | write strobe to csr with the read-modify-write value
//   RESP  | response held until writeback accepts it
module csr_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_value,
  input  logic [4:0]      req_rd_idx,
  output logic [11:0]     csr_addr,
  output logic            read_csr,
  input  logic [XLEN-1:0] csr_read_value,
  output logic            write_csr,
  output logic [XLEN-1:0] write_value,
  input  logic            csr_illegal,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd_idx,
  output logic [XLEN-1:0] resp_rd_value,
  output logic            resp_we,
  output logic            resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              ill_q, ill_d;
  logic              do_write_q, do_write_d;
  logic              read_csr_q, write_csr_q, resp_valid_q;
  logic              req_do_read;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      src_q        <= '0;
      old_q        <= '0;
      ill_q        <= 1'b0;
      do_write_q   <= 1'b0;
      read_csr_q   <= 1'b0;
      write_csr_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      src_q        <= src_d;
      old_q        <= old_d;
      ill_q        <= ill_d;
      do_write_q   <= do_write_d;
      // strobes decoded from the next state so they come straight off flops
      read_csr_q   <= (state_d == READ);
      write_csr_q  <= (state_d == WRITE);
      resp_valid_q <= (state_d == RESP);
    end
  end

  assign req_do_read = !((req_funct3[1:0] == OP_RW) && (req_rd_idx == 5'd0));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    src_d      = src_q;
    old_d      = old_q;
    ill_d      = ill_q;
    do_write_d = do_write_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = req_funct3[1:0];
          addr_d     = req_csr_addr;
          rd_d       = req_rd_idx;
          src_d      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_value;
          old_d      = '0;
          ill_d      = 1'b0;
          do_write_d = (req_funct3[1:0] == OP_RW) || (req_rs1_idx != 5'd0);
          if (req_funct3[1:0] == 2'b00) begin
            ill_d   = 1'b1;
            state_d = RESP;
          end else if (req_do_read) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        old_d = csr_read_value;
        ill_d = csr_illegal;
        if (!csr_illegal && do_write_q) state_d = WRITE;
        else                            state_d = RESP;
      end
      WRITE: begin
        ill_d   = ill_q | csr_illegal;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_value = '0;
    if (write_csr_q) begin
      case (op_q)
        OP_RW:   write_value = src_q;
        OP_RS:   write_value = old_q | src_q;
        OP_RC:   write_value = old_q & ~src_q;
        default: write_value = '0;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign read_csr      = read_csr_q;
  assign write_csr     = write_csr_q;
  assign csr_addr      = (read_csr_q || write_csr_q) ? addr_q : 12'd0;
  assign resp_valid    = resp_valid_q;
  assign resp_rd_idx   = rd_q;
  assign resp_rd_value = old_q;
  assign resp_we       = resp_valid_q && !ill_q && (rd_q != 5'd0);
  assign resp_illegal  = resp_valid_q && ill_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit with a small csr register model behind it.
module tb_csr_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b0;
  logic [11:0] req_csr_addr = 12'h0;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic [31:0] req_rs1_value = 32'h0;
  logic [4:0]  req_rd_idx = 5'd0;
  logic [11:0] csr_addr;
  logic        read_csr;
  logic [31:0] csr_read_value;
  logic        write_csr;
  logic [31:0] write_value;
  logic        csr_illegal;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [4:0]  resp_rd_idx;
  logic [31:0] resp_rd_value;
  logic        resp_we;
  logic        resp_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic        ill_rd = 1'b0;
  logic        ill_wr = 1'b0;
  logic [31:0] r_340 = 32'h0;
  logic [31:0] r_305 = 32'hFF;
  logic [31:0] last_wr = 32'h0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap = 0;

  csr_exec_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx),
    .req_rs1_value(req_rs1_value), .req_rd_idx(req_rd_idx),
    .csr_addr(csr_addr), .read_csr(read_csr), .csr_read_value(csr_read_value),
    .write_csr(write_csr), .write_value(write_value), .csr_illegal(csr_illegal),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_idx(resp_rd_idx),
    .resp_rd_value(resp_rd_value), .resp_we(resp_we), .resp_illegal(resp_illegal)
  );

  always #5 clock = ~clock;

  always_comb begin
    csr_read_value = 32'h0;
    case (csr_addr)
      12'hC00: csr_read_value = 32'h0000_1234;
      12'h340: csr_read_value = r_340;
      12'h305: csr_read_value = r_305;
      12'hC80: csr_read_value = 32'h0000_AAAA;
      default: csr_read_value = 32'h0;
    endcase
  end

  assign csr_illegal = (read_csr & ill_rd) | (write_csr & ill_wr);

  always @(posedge clock) begin
    if (read_csr) rd_cnt <= rd_cnt + 1;
    if (read_csr && write_csr) overlap <= overlap + 1;
    if (write_csr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= write_value;
      if (csr_addr == 12'h340) r_340 <= write_value;
      if (csr_addr == 12'h305) r_305 <= write_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drives one request for a single edge; caller is #1 after a posedge
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] val, input logic [4:0] rd);
    req_funct3 = f3; req_csr_addr = addr; req_rs1_idx = idx;
    req_rs1_value = val; req_rd_idx = rd; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("ready_after_hs", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int rd0, wr0;

    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_strobes", {30'b0, read_csr, write_csr}, 32'd0);
    check("rst_write_value", write_value, 32'h0);
    check("rst_csr_addr", {20'b0, csr_addr}, 32'h0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // CSRRS rd=5 rs1=x0: read only
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd5);
    check("rs_ready_low", {31'b0, req_ready}, 32'd0);
    check("rs_read_strobe", {31'b0, read_csr}, 32'd1);
    check("rs_read_addr", {20'b0, csr_addr}, 32'hC00);
    wait_resp(lat);
    check("rs_latency", lat, 2);
    check("rs_rd_value", resp_rd_value, 32'h1234);
    check("rs_we", {31'b0, resp_we}, 32'd1);
    check("rs_illegal", {31'b0, resp_illegal}, 32'd0);
    check("rs_rd_idx", {27'b0, resp_rd_idx}, 32'd5);
    check("rs_reads", rd_cnt - rd0, 1);
    check("rs_writes", wr_cnt - wr0, 0);
    handshake();

    // CSRRW rd=x0: write only
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd0);
    check("rw_write_value", write_value, 32'hDEAD_BEEF);
    wait_resp(lat);
    check("rw_latency", lat, 2);
    check("rw_reads", rd_cnt - rd0, 0);
    check("rw_writes", wr_cnt - wr0, 1);
    check("rw_last_wr", last_wr, 32'hDEAD_BEEF);
    check("rw_model", r_340, 32'hDEAD_BEEF);
    check("rw_we", {31'b0, resp_we}, 32'd0);
    check("rw_rd_value", resp_rd_value, 32'h0);
    handshake();

    // CSRRCI zimm=0x0F on 0xFF: read then write 0xF0
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(3'b111, 12'h305, 5'h0F, 32'h0, 5'd3);
    wait_resp(lat);
    check("rc_latency", lat, 3);
    check("rc_reads", rd_cnt - rd0, 1);
    check("rc_writes", wr_cnt - wr0, 1);
    check("rc_last_wr", last_wr, 32'hF0);
    check("rc_rd_value", resp_rd_value, 32'hFF);
    check("rc_we", {31'b0, resp_we}, 32'd1);
    handshake();

    // illegal raised during WRITE
    wr0 = wr_cnt;
    ill_wr = 1'b1;
    issue(3'b001, 12'hC80, 5'd9, 32'h1, 5'd2);
    wait_resp(lat);
    ill_wr = 1'b0;
    check("illw_latency", lat, 3);
    check("illw_illegal", {31'b0, resp_illegal}, 32'd1);
    check("illw_we", {31'b0, resp_we}, 32'd0);
    check("illw_writes", wr_cnt - wr0, 1);
    handshake();

    // illegal raised during READ: write skipped
    wr0 = wr_cnt;
    ill_rd = 1'b1;
    issue(3'b001, 12'hC80, 5'd9, 32'h1, 5'd2);
    wait_resp(lat);
    ill_rd = 1'b0;
    check("illr_latency", lat, 2);
    check("illr_illegal", {31'b0, resp_illegal}, 32'd1);
    check("illr_we", {31'b0, resp_we}, 32'd0);
    check("illr_writes", wr_cnt - wr0, 0);
    handshake();

    // funct3 op 00: straight to an illegal response, no csr access
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(3'b100, 12'h340, 5'd1, 32'h0, 5'd6);
    wait_resp(lat);
    check("op00_latency", lat, 1);
    check("op00_illegal", {31'b0, resp_illegal}, 32'd1);
    check("op00_we", {31'b0, resp_we}, 32'd0);
    check("op00_access", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    handshake();

    // response stall with a queued request behind it
    issue(3'b010, 12'hC00, 5'd0, 32'h0, 5'd5);
    wait_resp(lat);
    check("stall_latency", lat, 2);
    req_funct3 = 3'b110; req_csr_addr = 12'h305; req_rs1_idx = 5'd0;
    req_rs1_value = 32'h0; req_rd_idx = 5'd4; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("stall_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_rd_value", resp_rd_value, 32'h1234);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("hs_req_ready", {31'b0, req_ready}, 32'd1);
    check("hs_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("queued_accepted", {31'b0, req_ready}, 32'd0);
    wait_resp(lat);
    check("queued_latency", lat, 2);
    check("queued_rd_value", resp_rd_value, 32'hF0);
    check("queued_rd_idx", {27'b0, resp_rd_idx}, 32'd4);
    handshake();

    // reset asserted while in WRITE
    issue(3'b001, 12'h340, 5'd3, 32'h55, 5'd1);
    @(posedge clock); #1;
    check("pre_rst_write", {31'b0, write_csr}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_write", {31'b0, write_csr}, 32'd0);
    check("midrst_read", {31'b0, read_csr}, 32'd0);
    check("midrst_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_addr", {20'b0, csr_addr}, 32'h0);
    check("midrst_wval", write_value, 32'h0);
    @(negedge clock); reset = 1'b0;
    check("midrst_model", r_340, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    check("after_rst_ready", {31'b0, req_ready}, 32'd1);
    issue(3'b010, 12'hC00, 5'd0, 32'h0, 5'd5);
    wait_resp(lat);
    check("after_rst_latency", lat, 2);
    check("after_rst_rd_value", resp_rd_value, 32'h1234);
    check("after_rst_we", {31'b0, resp_we}, 32'd1);
    handshake();

    check("strobe_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
